// File: rtl/cpu_pkg.sv
// Shared RV32I decode constants, ALU operation encoding and load/store size codes.
package cpu_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

    localparam logic [2:0] MEM_B  = 3'b000;
    localparam logic [2:0] MEM_H  = 3'b001;
    localparam logic [2:0] MEM_W  = 3'b010;
    localparam logic [2:0] MEM_BU = 3'b100;
    localparam logic [2:0] MEM_HU = 3'b101;

    typedef enum logic [3:0] {
        AluAdd,
        AluSub,
        AluSll,
        AluSlt,
        AluSltu,
        AluXor,
        AluSrl,
        AluSra,
        AluOr,
        AluAnd
    } alu_op_e;

    // alt is instruction bit 30; it selects SUB only for register-register ops.
    function automatic alu_op_e alu_op_decode(input logic [2:0] funct3, input logic alt,
                                              input logic is_op);
        alu_op_e op;
        unique case (funct3)
            3'b000:  op = (is_op && alt) ? AluSub : AluAdd;
            3'b001:  op = AluSll;
            3'b010:  op = AluSlt;
            3'b011:  op = AluSltu;
            3'b100:  op = AluXor;
            3'b101:  op = alt ? AluSra : AluSrl;
            3'b110:  op = AluOr;
            default: op = AluAnd;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/cpu_alu.sv
// 32-bit integer ALU with equality and signed/unsigned less-than compare flags.
module cpu_alu
    import cpu_pkg::*;
(
    input  logic [31:0] op_a_i,
    input  logic [31:0] op_b_i,
    input  logic [3:0]  alu_op_i,
    output logic [31:0] result_o,
    output logic        eq_o,
    output logic        lt_o,
    output logic        ltu_o
);

    logic [4:0] shamt;

    always_comb begin
        shamt = op_b_i[4:0];
        eq_o  = (op_a_i == op_b_i);
        lt_o  = ($signed(op_a_i) < $signed(op_b_i));
        ltu_o = (op_a_i < op_b_i);
        unique case (alu_op_e'(alu_op_i))
            AluAdd:  result_o = op_a_i + op_b_i;
            AluSub:  result_o = op_a_i - op_b_i;
            AluSll:  result_o = op_a_i << shamt;
            AluSlt:  result_o = {31'b0, lt_o};
            AluSltu: result_o = {31'b0, ltu_o};
            AluXor:  result_o = op_a_i ^ op_b_i;
            AluSrl:  result_o = op_a_i >> shamt;
            AluSra:  result_o = $unsigned($signed(op_a_i) >>> shamt);
            AluOr:   result_o = op_a_i | op_b_i;
            AluAnd:  result_o = op_a_i & op_b_i;
            default: result_o = 32'b0;
        endcase
    end

endmodule

// File: rtl/cpu_top_level.sv
// Single-cycle RV32I core: PC, register file, decode, branch and load/store control.
// Define CPU_EBREAK_HALT_EN to make EBREAK halt the core until reset.
module cpu_top_level
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [31:0] INSTRUCTION,
    input  logic [31:0] MEM_data,
    output logic [31:0] Instr_Addr,
    output logic [31:0] MEM_addr,
    output logic [31:0] MEM_WR_out,
    output logic [2:0]  MEM_type,
    output logic        MEM_rd_en,
    output logic        MEM_wr_en
);

    logic [31:0] pc_q, pc_d;
    logic        run_q;
    logic        halted_q, halted_d;
    logic [31:0] rf_q [32];

    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] rs1_val, rs2_val, pc_plus4;

    logic [31:0] alu_a, alu_b, alu_res;
    alu_op_e     alu_op;
    logic        alu_eq, alu_lt, alu_ltu;

    logic        exec_en, rd_we, is_load, is_store, br_taken;
    logic [31:0] rd_wdata, pc_next;

    always_comb begin
        opcode   = INSTRUCTION[6:0];
        rd       = INSTRUCTION[11:7];
        funct3   = INSTRUCTION[14:12];
        rs1      = INSTRUCTION[19:15];
        rs2      = INSTRUCTION[24:20];
        imm_i    = {{20{INSTRUCTION[31]}}, INSTRUCTION[31:20]};
        imm_s    = {{20{INSTRUCTION[31]}}, INSTRUCTION[31:25], INSTRUCTION[11:7]};
        imm_b    = {{19{INSTRUCTION[31]}}, INSTRUCTION[31], INSTRUCTION[7],
                    INSTRUCTION[30:25], INSTRUCTION[11:8], 1'b0};
        imm_u    = {INSTRUCTION[31:12], 12'b0};
        imm_j    = {{11{INSTRUCTION[31]}}, INSTRUCTION[31], INSTRUCTION[19:12],
                    INSTRUCTION[20], INSTRUCTION[30:21], 1'b0};
        rs1_val  = (rs1 == 5'd0) ? 32'b0 : rf_q[rs1];
        rs2_val  = (rs2 == 5'd0) ? 32'b0 : rf_q[rs2];
        pc_plus4 = pc_q + 32'd4;
    end

    cpu_alu u_alu (
        .op_a_i   (alu_a),
        .op_b_i   (alu_b),
        .alu_op_i (alu_op),
        .result_o (alu_res),
        .eq_o     (alu_eq),
        .lt_o     (alu_lt),
        .ltu_o    (alu_ltu)
    );

    // run_q holds off execution for the first edge after reset is released.
    assign exec_en = Reset && run_q && !halted_q;

    always_comb begin
        alu_a    = rs1_val;
        alu_b    = imm_i;
        alu_op   = AluAdd;
        rd_we    = 1'b0;
        rd_wdata = alu_res;
        pc_next  = pc_plus4;
        is_load  = 1'b0;
        is_store = 1'b0;
        br_taken = 1'b0;
        halted_d = halted_q;
        unique case (opcode)
            OPC_LUI: begin
                rd_we    = 1'b1;
                rd_wdata = imm_u;
            end
            OPC_AUIPC: begin
                alu_a = pc_q;
                alu_b = imm_u;
                rd_we = 1'b1;
            end
            OPC_JAL: begin
                rd_we    = 1'b1;
                rd_wdata = pc_plus4;
                pc_next  = pc_q + imm_j;
            end
            OPC_JALR: begin
                rd_we    = 1'b1;
                rd_wdata = pc_plus4;
                pc_next  = {alu_res[31:1], 1'b0};
            end
            OPC_BRANCH: begin
                alu_b = rs2_val;
                unique case (funct3)
                    3'b000:  br_taken = alu_eq;
                    3'b001:  br_taken = !alu_eq;
                    3'b100:  br_taken = alu_lt;
                    3'b101:  br_taken = !alu_lt;
                    3'b110:  br_taken = alu_ltu;
                    3'b111:  br_taken = !alu_ltu;
                    default: br_taken = 1'b0;
                endcase
                if (br_taken) begin
                    pc_next = pc_q + imm_b;
                end
            end
            OPC_LOAD: begin
                is_load  = 1'b1;
                rd_we    = 1'b1;
                rd_wdata = MEM_data;
            end
            OPC_STORE: begin
                is_store = 1'b1;
                alu_b    = imm_s;
            end
            OPC_OP_IMM: begin
                rd_we  = 1'b1;
                alu_op = alu_op_decode(funct3, INSTRUCTION[30], 1'b0);
            end
            OPC_OP: begin
                rd_we  = 1'b1;
                alu_b  = rs2_val;
                alu_op = alu_op_decode(funct3, INSTRUCTION[30], 1'b1);
            end
            OPC_SYSTEM: begin
`ifdef CPU_EBREAK_HALT_EN
                if (INSTRUCTION == INSTR_EBREAK) begin
                    pc_next  = pc_q;
                    halted_d = exec_en;
                end
`endif
            end
            default: ;
        endcase

        if (!exec_en) begin
            rd_we    = 1'b0;
            is_load  = 1'b0;
            is_store = 1'b0;
            pc_next  = pc_q;
            halted_d = halted_q;
        end
        pc_d = pc_next;
    end

    always_comb begin
        Instr_Addr = pc_q;
        MEM_rd_en  = is_load;
        MEM_wr_en  = is_store;
        MEM_addr   = (is_load || is_store) ? alu_res : 32'b0;
        MEM_WR_out = is_store ? rs2_val : 32'b0;
        MEM_type   = (is_load || is_store) ? funct3 : MEM_B;
    end

    always_ff @(posedge CLK) begin
        if (!Reset) begin
            pc_q     <= RESET_PC;
            run_q    <= 1'b0;
            halted_q <= 1'b0;
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= 32'b0;
            end
        end else begin
            pc_q     <= pc_d;
            run_q    <= 1'b1;
            halted_q <= halted_d;
            if (rd_we && (rd != 5'd0)) begin
                rf_q[rd] <= rd_wdata;
            end
        end
    end

endmodule

// File: tb/tb_cpu_top_level.sv
// Directed-program bench for cpu_top_level with behavioural instruction and byte data memory.
module tb_cpu_top_level;

    logic        CLK = 1'b0;
    logic        Reset;
    logic [31:0] INSTRUCTION, MEM_data;
    logic [31:0] Instr_Addr, MEM_addr, MEM_WR_out;
    logic [2:0]  MEM_type;
    logic        MEM_rd_en, MEM_wr_en;

    logic [31:0] imem [0:127];
    logic [7:0]  dmem [0:255];
    logic [7:0]  da;
    logic [31:0] dword;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef CPU_EBREAK_HALT_EN
    localparam logic [31:0] EXP_PC_END = 32'h0000_005C;
    localparam logic [31:0] EXP_X16    = 32'h0;
`else
    localparam logic [31:0] EXP_PC_END = 32'h0000_0064;
    localparam logic [31:0] EXP_X16    = 32'h1;
`endif

    cpu_top_level #(.RESET_PC(32'h0000_0000)) dut (
        .CLK         (CLK),
        .Reset       (Reset),
        .INSTRUCTION (INSTRUCTION),
        .MEM_data    (MEM_data),
        .Instr_Addr  (Instr_Addr),
        .MEM_addr    (MEM_addr),
        .MEM_WR_out  (MEM_WR_out),
        .MEM_type    (MEM_type),
        .MEM_rd_en   (MEM_rd_en),
        .MEM_wr_en   (MEM_wr_en)
    );

    always #5 CLK = ~CLK;

    assign INSTRUCTION = imem[Instr_Addr[8:2]];

    always_comb begin
        da    = MEM_addr[7:0];
        dword = {dmem[da + 8'd3], dmem[da + 8'd2], dmem[da + 8'd1], dmem[da]};
        case (MEM_type)
            3'b000:  MEM_data = {{24{dword[7]}}, dword[7:0]};
            3'b001:  MEM_data = {{16{dword[15]}}, dword[15:0]};
            3'b100:  MEM_data = {24'b0, dword[7:0]};
            3'b101:  MEM_data = {16'b0, dword[15:0]};
            default: MEM_data = dword;
        endcase
    end

    always @(posedge CLK) begin
        if (MEM_wr_en) begin
            dmem[da] <= MEM_WR_out[7:0];
            if (MEM_type[1:0] != 2'b00) dmem[da + 8'd1] <= MEM_WR_out[15:8];
            if (MEM_type[1:0] == 2'b10) begin
                dmem[da + 8'd2] <= MEM_WR_out[23:16];
                dmem[da + 8'd3] <= MEM_WR_out[31:24];
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 128; i++) imem[i] = 32'h0;
        for (int i = 0; i < 256; i++) dmem[i] = 8'h0;
        imem[8'h00 >> 2] = 32'h0050_0093; // addi x1,x0,5
        imem[8'h04 >> 2] = 32'hFF90_8113; // addi x2,x1,-7
        imem[8'h08 >> 2] = 32'h0020_2623; // sw   x2,12(x0)
        imem[8'h0C >> 2] = 32'h00C0_0183; // lb   x3,12(x0)
        imem[8'h10 >> 2] = 32'h00C0_4203; // lbu  x4,12(x0)
        imem[8'h14 >> 2] = 32'h8000_0337; // lui  x6,0x80000
        imem[8'h18 >> 2] = 32'h01F0_0393; // addi x7,x0,31
        imem[8'h1C >> 2] = 32'h4073_5433; // sra  x8,x6,x7
        imem[8'h20 >> 2] = 32'h0000_0863; // beq  x0,x0,+16
        imem[8'h24 >> 2] = 32'h0010_0493; // addi x9,x0,1 (skipped)
        imem[8'h28 >> 2] = 32'h0010_0493;
        imem[8'h2C >> 2] = 32'h0010_0493;
        imem[8'h30 >> 2] = 32'h0011_6463; // bltu x2,x1,+8
        imem[8'h34 >> 2] = 32'h0073_5533; // srl  x10,x6,x7
        imem[8'h38 >> 2] = 32'h0070_0013; // addi x0,x0,7
        imem[8'h3C >> 2] = 32'h4020_85B3; // sub  x11,x1,x2
        imem[8'h40 >> 2] = 32'h1000_02EF; // jal  x5,+0x100
        imem[9'h140 >> 2] = 32'h0012_8067; // jalr x0,1(x5)
        imem[8'h44 >> 2] = 32'h0000_1617; // auipc x12,1
        imem[8'h48 >> 2] = 32'h0011_26B3; // slt  x13,x2,x1
        imem[8'h4C >> 2] = 32'h0011_3733; // sltu x14,x2,x1
        imem[8'h50 >> 2] = 32'hFFF0_C793; // xori x15,x1,-1
        imem[8'h54 >> 2] = 32'h0010_1823; // sh   x1,16(x0)
        imem[8'h58 >> 2] = 32'h00B0_2A23; // sw   x11,20(x0)
        imem[8'h5C >> 2] = 32'h0010_0073; // ebreak
        imem[8'h60 >> 2] = 32'h0010_0813; // addi x16,x0,1

        Reset = 1'b0;
        repeat (3) step();
        check_eq("rst_pc", Instr_Addr, 32'h0);
        check_eq("rst_wr_en", {31'b0, MEM_wr_en}, 32'h0);
        Reset = 1'b1;
        step();
        check_eq("warmup_pc", Instr_Addr, 32'h0);
        check_eq("warmup_x1", dut.rf_q[1], 32'h0);
        step();
        check_eq("addi_x1", dut.rf_q[1], 32'd5);
        step();
        check_eq("addi_x2", dut.rf_q[2], 32'hFFFF_FFFE);
        check_eq("pc_after_2", Instr_Addr, 32'h8);
        check_eq("sw_wr_en", {31'b0, MEM_wr_en}, 32'h1);
        check_eq("sw_rd_en", {31'b0, MEM_rd_en}, 32'h0);
        check_eq("sw_addr", MEM_addr, 32'd12);
        check_eq("sw_type", {29'b0, MEM_type}, 32'h2);
        check_eq("sw_data", MEM_WR_out, 32'hFFFF_FFFE);
        step();
        check_eq("lb_rd_en", {31'b0, MEM_rd_en}, 32'h1);
        step();
        check_eq("lb_x3", dut.rf_q[3], 32'hFFFF_FFFE);
        step();
        check_eq("lbu_x4", dut.rf_q[4], 32'h0000_00FE);
        repeat (3) step();
        check_eq("lui_x6", dut.rf_q[6], 32'h8000_0000);
        check_eq("sra_x8", dut.rf_q[8], 32'hFFFF_FFFF);
        check_eq("beq_at", Instr_Addr, 32'h20);
        step();
        check_eq("beq_taken_pc", Instr_Addr, 32'h30);
        step();
        check_eq("bltu_not_taken_pc", Instr_Addr, 32'h34);
        step();
        check_eq("srl_x10", dut.rf_q[10], 32'h1);
        step();
        check_eq("x0_stays_0", dut.rf_q[0], 32'h0);
        step();
        check_eq("sub_x11", dut.rf_q[11], 32'd7);
        step();
        check_eq("jal_pc", Instr_Addr, 32'h140);
        check_eq("jal_x5", dut.rf_q[5], 32'h44);
        step();
        check_eq("jalr_pc", Instr_Addr, 32'h44);
        step();
        check_eq("auipc_x12", dut.rf_q[12], 32'h0000_1044);
        step();
        check_eq("slt_x13", dut.rf_q[13], 32'h1);
        step();
        check_eq("sltu_x14", dut.rf_q[14], 32'h0);
        step();
        check_eq("xori_x15", dut.rf_q[15], 32'hFFFF_FFFA);
        check_eq("skipped_x9", dut.rf_q[9], 32'h0);
        step();
        check_eq("sh_mem", {16'b0, dmem[17], dmem[16]}, 32'h0005);
        check_eq("sw2_wr_en", {31'b0, MEM_wr_en}, 32'h1);

        // Reset lands in the middle of the store at 0x58.
        Reset = 1'b0;
        #1;
        check_eq("rstmid_wr_en", {31'b0, MEM_wr_en}, 32'h0);
        check_eq("rstmid_addr", MEM_addr, 32'h0);
        check_eq("rstmid_wdata", MEM_WR_out, 32'h0);
        check_eq("rstmid_type", {29'b0, MEM_type}, 32'h0);
        step();
        check_eq("rstmid_pc", Instr_Addr, 32'h0);
        check_eq("rstmid_x1", dut.rf_q[1], 32'h0);
        check_eq("rstmid_x11", dut.rf_q[11], 32'h0);
        check_eq("rstmid_mem", {dmem[23], dmem[22], dmem[21], dmem[20]}, 32'h0);

        Reset = 1'b1;
        for (int i = 0; i < 100 && Instr_Addr != 32'h5C; i++) step();
        check_eq("reach_ebreak", Instr_Addr, 32'h5C);
        check_eq("sw2_mem", {dmem[23], dmem[22], dmem[21], dmem[20]}, 32'd7);
        repeat (2) step();
        check_eq("ebreak_pc", Instr_Addr, EXP_PC_END);
        check_eq("ebreak_x16", dut.rf_q[16], EXP_X16);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_top_level.md
# cpu_top_level

Single-cycle RV32I integer core: one instruction fetched, executed and retired per clock. Sits between a combinational-read instruction memory (driven by `Instr_Addr`, returns `INSTRUCTION`) and a data memory with combinational read and clocked write (driven by `MEM_addr`/`MEM_WR_out`/`MEM_type`/enables, returns `MEM_data`). The core contains the PC, the 32×32 register file, decode, ALU, branch and load/store control.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC value loaded during reset.

Ports:
- `CLK` in 1: single clock, all state updates on rising edge.
- `Reset` in 1: reset is synchronous and active-low.
- `INSTRUCTION` in 32: instruction at `Instr_Addr`, valid the same cycle.
- `MEM_data` in 32: load data, already sized and sign/zero-extended by memory per `MEM_type`, valid the same cycle.
- `Instr_Addr` out 32: current PC.
- `MEM_addr` out 32: load/store byte address, rs1 + imm.
- `MEM_WR_out` out 32: store data, unmodified rs2; memory uses low bytes per size.
- `MEM_type` out 3: funct3 of the load/store (000 B, 001 H, 010 W, 100 BU, 101 HU).
- `MEM_rd_en` out 1: high for load instructions.
- `MEM_wr_en` out 1: high for store instructions; memory writes on that `CLK` edge.

## Operation
- Supported: LUI, AUIPC, JAL, JALR, BEQ/BNE/BLT/BGE/BLTU/BGEU, LB/LH/LW/LBU/LHU, SB/SH/SW, all OP-IMM and OP (ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND).
- FENCE, ECALL, CSR, and unrecognised opcodes execute as NOP: PC+4, no register write, enables low.
- x0 reads 0; writes to x0 are discarded.
- Next PC: PC+4 by default; branch taken → PC+B-imm; JAL → PC+J-imm; JALR → (rs1+I-imm) & ~1. JAL/JALR write PC+4 to rd.
- Shift amount is the low 5 bits of rs2/shamt; SRA/SRAI sign-fill. SLT signed, SLTU unsigned. All arithmetic mod 2^32, no overflow trap.
- Misaligned addresses: no trap; the address is passed through unchanged.
- Reset (`Reset`=0 at a rising edge): PC←`RESET_PC`, all registers←0. While `Reset`=0: `MEM_rd_en`=0, `MEM_wr_en`=0, `MEM_addr`=0, `MEM_WR_out`=0, `MEM_type`=0, `Instr_Addr`=PC, no register writes. Reset asserted mid-program aborts the current instruction with no side effects.

## Timing
- CPI = 1; no stalls, no pipeline, no hazards.
- Register and PC writes occur at the rising `CLK` edge ending the instruction. A read of an rd being written in the same cycle returns the old value.
- All memory outputs are combinational from PC, `INSTRUCTION` and the register file.
- Load result from `MEM_data` is written to rd at the same edge.
- First fetch at `RESET_PC` occurs in the cycle after the first edge with `Reset`=1.

## Configuration
- `CPU_EBREAK_HALT_EN`: when defined, EBREAK (32'h0010_0073) freezes the PC at the EBREAK address, with no register or memory writes, until reset.
- When undefined, EBREAK is a NOP.

## Structure
- Package `cpu_pkg`: opcode constants (LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP_IMM, OP, SYSTEM), the ALU operation enum, and the funct3 load/store size constants.
- One sub-module, `cpu_alu`: two 32-bit operands, ALU op, 32-bit result plus branch compare flags.
- Register file, decode and PC logic live in the top.

## Test plan
- Reset then `addi x1,x0,5`; `addi x2,x1,-7` → x1=5, x2=32'hFFFF_FFFE, PC=8 after 2 cycles.
- `sw x2,12(x0)`; `lb x3,12(x0)`; `lbu x4,12(x0)` with byte memory → store cycle: `MEM_wr_en`=1, `MEM_addr`=12, `MEM_type`=010. Then x3=32'hFFFF_FFFE, x4=32'h0000_00FE.
- `beq x0,x0,+16` at PC 0x20 → next PC 0x30. `bltu x2,x1,+8` with x2 ≫ x1 unsigned → not taken, PC+4.
- `jal x5,+0x100` at PC 0x40 → PC=0x140, x5=0x44. `jalr x0,1(x5)` → PC=0x44.
- `sra` of 32'h8000_0000 by 31 → 32'hFFFF_FFFF; `srl` → 1; write to x0 leaves x0=0.
- Assert `Reset`=0 during a store cycle → `MEM_wr_en`=0, PC=`RESET_PC` next cycle, all registers 0.
